instruction_loader: RTL and testbench

//  Writer side of the instruction memory: receives a program as a byte stream
//  (valid/ready) and writes it word-by-word into the instruction memory write port.

---
 rtl/instruction_loader_pkg.sv | 18 +
 rtl/instruction_loader_word_assembler.sv | 47 ++++
 rtl/instruction_loader.sv | 126 ++++++++++++
 tb/tb_instruction_loader.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instruction_loader_pkg.sv
// rtl/instruction_loader_pkg.sv - shared types and defaults for the instruction loader
// Purpose: loader FSM state encoding and default geometry of the instruction memory.
// Ports: none (package).
package instruction_loader_pkg;

  localparam int DEFAULT_WORD_WIDTH = 32;
  localparam int DEFAULT_MEM_DEPTH  = 256;
  localparam int DEFAULT_ADDR_WIDTH = 8;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_HEADER  = 3'd1,
    ST_PAYLOAD = 3'd2,
    ST_DONE    = 3'd3,
    ST_ERROR   = 3'd4
  } loader_state_t;

endpackage

// File: rtl/instruction_loader_word_assembler.sv
// rtl/instruction_loader_word_assembler.sv - MSB-first byte to word assembler
// Purpose: shifts accepted bytes into a word and flags the strobe carrying the last byte.
// Ports:
//   clk, reset      clock, asynchronous active-low reset
//   byte_data       byte being accepted
//   strobe          byte_data is accepted this cycle
//   clear           restart byte count (wins over strobe)
//   word            word including the current byte, valid when word_valid
//   word_valid      combinational: this strobe completes a word
module instruction_loader_word_assembler #(
  parameter int WORD_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            byte_data,
  input  logic                  strobe,
  input  logic                  clear,
  output logic [WORD_WIDTH-1:0] word,
  output logic                  word_valid
);

  localparam int BYTES = WORD_WIDTH / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES - 1);

  logic [CNT_W-1:0]      count;
  logic [WORD_WIDTH-1:0] shift;

  // Full-width shift: after BYTES strobes every stale bit of the previous
  // word has been pushed out, so no per-word clear of the data is needed.
  assign word       = (shift << 8) | WORD_WIDTH'(byte_data);
  assign word_valid = strobe && (count == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
      shift <= '0;
    end else if (clear) begin
      count <= '0;
      shift <= '0;
    end else if (strobe) begin
      shift <= word;
      count <= (count == LAST) ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/instruction_loader.sv
// rtl/instruction_loader.sv - byte-stream program loader for the instruction memory
// Purpose: reads header N then N MSB-first words from a byte stream and writes them
//   to the instruction memory, holding the CPU in reset while loading.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start                      pulse; begins a load when not busy
//   in_valid/in_data/in_ready  byte stream handshake
//   mem_we/mem_addr/mem_wdata  instruction memory write port
//   num_instructions           N from the header
//   busy, cpu_hold             load in progress
//   load_done, error           sticky status until next start
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
  parameter int MEM_DEPTH  = DEFAULT_MEM_DEPTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  in_valid,
  input  logic [7:0]            in_data,
  output logic                  in_ready,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [WORD_WIDTH-1:0] mem_wdata,
  output logic [WORD_WIDTH-1:0] num_instructions,
  output logic                  busy,
  output logic                  cpu_hold,
  output logic                  load_done,
  output logic                  error
);

  loader_state_t         state, next_state;
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [WORD_WIDTH-1:0] asm_word;
  logic                  asm_valid;
  logic                  accept;
  logic                  restart;
  logic                  last_written;
  logic                  header_word;
  logic                  payload_word;

  assign busy     = (state == ST_HEADER) || (state == ST_PAYLOAD);
  assign cpu_hold = busy;
  // The write cycle is the one-per-word bubble on the stream.
  assign in_ready = busy && !mem_we;
  assign accept   = in_valid && in_ready;
  assign restart  = start && !busy;

  assign header_word  = (state == ST_HEADER)  && accept && asm_valid;
  assign payload_word = (state == ST_PAYLOAD) && accept && asm_valid;
  assign last_written = mem_we &&
                        (WORD_WIDTH'(mem_addr) == num_instructions - WORD_WIDTH'(1));

  instruction_loader_word_assembler #(
    .WORD_WIDTH (WORD_WIDTH)
  ) u_assembler (
    .clk        (clk),
    .reset      (reset),
    .byte_data  (in_data),
    .strobe     (accept),
    .clear      (restart),
    .word       (asm_word),
    .word_valid (asm_valid)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= ST_IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: if (start) next_state = ST_HEADER;
      ST_HEADER: begin
        if (header_word) begin
          if (asm_word == '0)                             next_state = ST_DONE;
          else if (asm_word > WORD_WIDTH'(MEM_DEPTH))     next_state = ST_ERROR;
          else                                            next_state = ST_PAYLOAD;
        end
      end
      // Leave PAYLOAD at the end of the final write cycle, not when its data arrives.
      ST_PAYLOAD: if (last_written) next_state = ST_DONE;
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      num_instructions <= '0;
      load_done        <= 1'b0;
      error            <= 1'b0;
      word_idx         <= '0;
    end else begin
      mem_we <= 1'b0;
      if (restart) begin
        load_done        <= 1'b0;
        error            <= 1'b0;
        num_instructions <= '0;
        word_idx         <= '0;
      end
      if (header_word) begin
        num_instructions <= asm_word;
        word_idx         <= '0;
        if (asm_word == '0)                         load_done <= 1'b1;
        else if (asm_word > WORD_WIDTH'(MEM_DEPTH)) error     <= 1'b1;
      end
      if (payload_word) begin
        mem_we    <= 1'b1;
        mem_addr  <= word_idx;
        mem_wdata <= asm_word;
      end
      if ((state == ST_PAYLOAD) && mem_we) begin
        word_idx <= word_idx + ADDR_WIDTH'(1);
        if (last_written) load_done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_instruction_loader.sv
// tb/tb_instruction_loader.sv - directed self-checking bench for instruction_loader
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic        in_valid = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] num_instructions;
  logic        busy;
  logic        cpu_hold;
  logic        load_done;
  logic        error;

  int checks = 0;
  int errors = 0;
  int ready_viol = 0;
  logic [7:0]  wr_addr[$];
  logic [31:0] wr_data[$];

  instruction_loader #(
    .WORD_WIDTH (32),
    .MEM_DEPTH  (256),
    .ADDR_WIDTH (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .in_valid         (in_valid),
    .in_data          (in_data),
    .in_ready         (in_ready),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .num_instructions (num_instructions),
    .busy             (busy),
    .cpu_hold         (cpu_hold),
    .load_done        (load_done),
    .error            (error)
  );

  always #5 clk = ~clk;

  // Write log plus stream-ready rule: ready low exactly in write cycles while busy.
  always @(negedge clk) begin
    if (reset) begin
      if (mem_we) begin
        wr_addr.push_back(mem_addr);
        wr_data.push_back(mem_wdata);
      end
      if (mem_we && in_ready) ready_viol++;
      if (busy && !mem_we && !in_ready) ready_viol++;
      if (mem_we && !busy) ready_viol++;
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gaps);
    int t = 0;
    if (gaps && $urandom_range(0, 1) == 1) begin
      repeat ($urandom_range(1, 2)) begin @(posedge clk); #1; end
    end
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin
      checks++; errors++;
      $display("FAIL send_byte timeout byte=%02h in_ready=%0b required=1", b, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 8'hxx;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], gaps);
  endtask

  task automatic wait_end();
    int t = 0;
    @(negedge clk);
    while (!(load_done || error) && t < 100) begin @(negedge clk); t++; end
    if (t >= 100) begin
      checks++; errors++;
      $display("FAIL wait_end timeout load_done=%0b error=%0b required=1", load_done, error);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({in_ready, mem_we, busy, cpu_hold, load_done, error} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags got=%06b required=000000",
               {in_ready, mem_we, busy, cpu_hold, load_done, error});
    end
    checks++;
    if ({mem_addr, mem_wdata, num_instructions} !== 72'h0) begin
      errors++;
      $display("FAIL reset_regs addr=%0h wdata=%0h n=%0h required=0", mem_addr, mem_wdata, num_instructions);
    end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    wr_addr.delete(); wr_data.delete(); ready_viol = 0;
    pulse_start();
    checks++;
    if (busy !== 1'b1 || cpu_hold !== 1'b1) begin
      errors++; $display("FAIL basic_busy got=%0b%0b required=11", busy, cpu_hold);
    end
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h1234_5678, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    @(negedge clk);
    checks++;
    if (mem_we !== 1'b1 || mem_addr !== 8'd1 || load_done !== 1'b0) begin
      errors++;
      $display("FAIL basic_last_write we=%0b addr=%0d done=%0b required we=1 addr=1 done=0",
               mem_we, mem_addr, load_done);
    end
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || busy !== 1'b0 || cpu_hold !== 1'b0 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL basic_done done=%0b busy=%0b hold=%0b ready=%0b required 1000",
               load_done, busy, cpu_hold, in_ready);
    end
    checks++;
    if (num_instructions !== 32'd2) begin
      errors++; $display("FAIL basic_n got=%0d required=2", num_instructions);
    end
    checks++;
    if (wr_addr.size() != 2) begin
      errors++; $display("FAIL basic_write_count got=%0d required=2", wr_addr.size());
    end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'h1234_5678 ||
                 wr_addr[1] !== 8'd1 || wr_data[1] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL basic_writes got %0d:%08h %0d:%08h required 0:12345678 1:deadbeef",
               wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    checks++;
    if (ready_viol != 0) begin
      errors++; $display("FAIL basic_bubble violations=%0d required=0", ready_viol);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_zero();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0000, 1'b0);
    @(negedge clk);
    checks++;
    if (load_done !== 1'b1 || in_ready !== 1'b0 || num_instructions !== 32'd0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL zero_done done=%0b ready=%0b n=%0d busy=%0b required 1 0 0 0",
               load_done, in_ready, num_instructions, busy);
    end
    // Bytes offered in DONE must not be consumed.
    in_valid = 1'b1; in_data = 8'h55;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (in_ready !== 1'b0) begin
        errors++; $display("FAIL zero_hold_ready got=%0b required=0", in_ready);
      end
    end
    in_valid = 1'b0;
    checks++;
    if (wr_addr.size() != 0) begin
      errors++; $display("FAIL zero_writes got=%0d required=0", wr_addr.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_error();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0101, 1'b0);
    @(negedge clk);
    checks++;
    if (error !== 1'b1 || load_done !== 1'b0 || num_instructions !== 32'h101 || busy !== 1'b0) begin
      errors++;
      $display("FAIL err_flag err=%0b done=%0b n=%0h busy=%0b required 1 0 101 0",
               error, load_done, num_instructions, busy);
    end
    @(posedge clk); #1;
    pulse_start();
    checks++;
    if (error !== 1'b0 || num_instructions !== 32'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL err_restart err=%0b n=%0h busy=%0b required 0 0 1", error, num_instructions, busy);
    end
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hCAFE_F00D, 1'b0);
    wait_end();
    checks++;
    if (load_done !== 1'b1 || error !== 1'b0 || wr_addr.size() != 1) begin
      errors++;
      $display("FAIL err_reload done=%0b err=%0b writes=%0d required 1 0 1", load_done, error, wr_addr.size());
    end else if (wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hCAFE_F00D) begin
      errors++;
      $display("FAIL err_reload_data got %0d:%08h required 0:cafef00d", wr_addr[0], wr_data[0]);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_gaps();
    logic [31:0] prog [3];
    prog[0] = 32'hA1B2_C3D4; prog[1] = 32'h0102_0304; prog[2] = 32'hFFEE_DDCC;
    wr_addr.delete(); wr_data.delete(); ready_viol = 0;
    pulse_start();
    send_word(32'h0000_0003, 1'b1);
    for (int i = 0; i < 3; i++) send_word(prog[i], 1'b1);
    wait_end();
    checks++;
    if (wr_addr.size() != 3) begin
      errors++; $display("FAIL gaps_count got=%0d required=3", wr_addr.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (wr_addr[i] !== 8'(i) || wr_data[i] !== prog[i]) begin
          errors++;
          $display("FAIL gaps_write%0d got %0d:%08h required %0d:%08h", i, wr_addr[i], wr_data[i], i, prog[i]);
        end
      end
    end
    checks++;
    if (ready_viol != 0 || load_done !== 1'b1) begin
      errors++; $display("FAIL gaps_bubble viol=%0d done=%0b required 0 1", ready_viol, load_done);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h1111_2222, 1'b0);
    send_byte(8'h33, 1'b0);
    send_byte(8'h44, 1'b0);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({in_ready, mem_we, busy, cpu_hold, load_done, error} !== 6'b0 ||
        {mem_addr, mem_wdata, num_instructions} !== 72'h0) begin
      errors++;
      $display("FAIL midreset_async flags=%06b addr=%0h wdata=%0h n=%0h required all 0",
               {in_ready, mem_we, busy, cpu_hold, load_done, error}, mem_addr, mem_wdata, num_instructions);
    end
    checks++;
    if (wr_addr.size() != 1 || wr_data[0] !== 32'h1111_2222) begin
      errors++; $display("FAIL midreset_written count=%0d required=1 with 11112222", wr_addr.size());
    end
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0001, 1'b0);
    send_word(32'hAABB_CCDD, 1'b0);
    wait_end();
    checks++;
    if (wr_addr.size() != 1 || wr_addr[0] !== 8'd0 || wr_data[0] !== 32'hAABB_CCDD) begin
      errors++; $display("FAIL midreset_reload count=%0d required 1 write 0:aabbccdd", wr_addr.size());
    end
    @(posedge clk); #1;
  endtask

  task automatic test_start_busy();
    wr_addr.delete(); wr_data.delete();
    pulse_start();
    send_word(32'h0000_0002, 1'b0);
    send_word(32'h0BAD_F00D, 1'b0);
    send_byte(8'h76, 1'b0);
    pulse_start();
    checks++;
    if (busy !== 1'b1 || num_instructions !== 32'd2) begin
      errors++; $display("FAIL busy_start busy=%0b n=%0d required 1 2", busy, num_instructions);
    end
    send_byte(8'h54, 1'b0);
    send_byte(8'h32, 1'b0);
    send_byte(8'h10, 1'b0);
    wait_end();
    checks++;
    if (wr_addr.size() != 2 || wr_data[0] !== 32'h0BAD_F00D || wr_data[1] !== 32'h7654_3210 ||
        wr_addr[1] !== 8'd1 || load_done !== 1'b1 || num_instructions !== 32'd2) begin
      errors++;
      $display("FAIL busy_complete writes=%0d done=%0b n=%0d required 2 writes, done=1, n=2",
               wr_addr.size(), load_done, num_instructions);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_error();
    test_gaps();
    test_reset_mid();
    test_start_busy();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
